ram_reader: RTL and testbench

Read-side DMA engine for the 1K×8 CPU RAM. It takes a base address and length, issues sequential reads on the RAM's single port, and absorbs the RAM's one-cycle unregistered read latency. Bytes leave on a valid/ready stream with full backpressure. It sits between the CPU RAM and the telemetry/serial transmit path, and owns the RAM port while busy.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_reader_fifo2.sv | 48 ++++
 rtl/ram_reader.sv | 122 ++++++++++++
 tb/tb_ram_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants, length type and FSM state encoding for the CPU RAM reader.
package ram_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 10;
  localparam int unsigned RAM_DATA_WIDTH = 8;

  typedef logic [RAM_ADDR_WIDTH:0] len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/ram_reader_fifo2.sv
// Two-entry FIFO that buffers RAM read data ahead of the output stream.
module ram_reader_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_reader.sv
// Read-side DMA engine: streams Length bytes from the CPU RAM starting at Base.
// Define RAM_READER_SUM_EN to add the Sum output (mod-2**DATA_WIDTH sum of popped bytes).
module ram_reader
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [ADDR_WIDTH-1:0] Base,
  input  logic [ADDR_WIDTH:0]   Length,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] RamAddr,
  output logic                  RamCE,
  output logic                  RamWE,
  input  logic [DATA_WIDTH-1:0] RamQ,
  output logic [DATA_WIDTH-1:0] StrData,
  output logic                  StrValid,
  input  logic                  StrReady
`ifdef RAM_READER_SUM_EN
  ,
  output logic [DATA_WIDTH-1:0] Sum
`endif
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  in_flight_q;
  logic [1:0]            occ;
  logic                  pop;
  logic                  issue;
  logic                  credit_ok;
  logic                  start_acc;
  logic                  abort_act;

  assign pop       = StrValid & StrReady;
  assign start_acc = (state_q == IDLE) && Start;
  assign abort_act = Abort && ((state_q == READ) || (state_q == DRAIN));
  // Buffered plus in-flight bytes, net of this cycle's pop, must leave room for the new read.
  assign credit_ok = ({1'b0, occ} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = (Length == '0) ? DONE : READ;
      end
      READ: begin
        if (Abort) begin
          state_d = IDLE;
        end else begin
          issue = credit_ok;
          if (issue && (remain_q == (ADDR_WIDTH+1)'(1))) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (Abort) state_d = IDLE;
        else if (pop && (occ == 2'd1) && !in_flight_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      if (start_acc) begin
        addr_q   <= Base;
        remain_q <= Length;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_WIDTH'(1);
        remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  ram_reader_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .flush_i(abort_act),
    .push_i (in_flight_q),
    .data_i (RamQ),
    .pop_i  (pop),
    .data_o (StrData),
    .count_o(occ)
  );

  assign StrValid = (occ != 2'd0);
  assign Busy     = (state_q == READ) || (state_q == DRAIN);
  assign Done     = (state_q == DONE);
  assign RamCE    = issue;
  assign RamWE    = 1'b0;
  assign RamAddr  = addr_q;

`ifdef RAM_READER_SUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)         sum_q <= '0;
    else if (start_acc) sum_q <= '0;
    else if (pop)       sum_q <= sum_q + StrData;
  end

  assign Sum = sum_q;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: table of transfers plus abort, reset and optional Sum sequences.
module tb_ram_reader;
  import ram_pkg::*;

  localparam int unsigned AW = RAM_ADDR_WIDTH;
  localparam int unsigned DW = RAM_DATA_WIDTH;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic [AW-1:0] Base = '0;
  len_t          Length = '0;
  logic          StrReady = 1'b0;
  logic          Busy, Done, RamCE, RamWE, StrValid;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamQ, StrData;
`ifdef RAM_READER_SUM_EN
  logic [DW-1:0] Sum;
`endif

  ram_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Abort   (Abort),
    .Base    (Base),
    .Length  (Length),
    .Busy    (Busy),
    .Done    (Done),
    .RamAddr (RamAddr),
    .RamCE   (RamCE),
    .RamWE   (RamWE),
    .RamQ    (RamQ),
    .StrData (StrData),
    .StrValid(StrValid),
    .StrReady(StrReady)
`ifdef RAM_READER_SUM_EN
    ,
    .Sum     (Sum)
`endif
  );

  always #5 Clock = ~Clock;

  logic [DW-1:0] mem [1 << AW];
  always @(posedge Clock) if (RamCE) RamQ <= mem[RamAddr];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got[$];
  logic [AW-1:0] addrs[$];
  int done_cnt, done_cyc, ce_cnt, valid_cnt, cred_viol, hold_viol, post_abort_bad;
  logic busy_end;

  typedef struct {
    logic [AW-1:0] base;
    int unsigned   len;
    int            ready_mode;  // 0: ready held high, 1: pseudo-random
    bit            start_mid;
    int            exp_n;
    int            exp_first;
    int            exp_done;    // -1: cycle not fixed
    int            exp_valid;   // -1: not fixed
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [AW-1:0] b, input int unsigned l, input int ready_mode,
                     input int abort_after, input bit start_mid, input int max_cyc);
    int  issued = 0;
    int  popped = 0;
    int  abort_cyc = -1;
    bit  pop;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    got.delete();
    addrs.delete();
    done_cnt = 0; done_cyc = -1; ce_cnt = 0; valid_cnt = 0;
    cred_viol = 0; hold_viol = 0; post_abort_bad = 0; busy_end = 1'b1;
    @(posedge Clock); #1;
    Base = b; Length = l[AW:0]; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      Abort    = 1'b0;
      StrReady = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      Start    = start_mid && (cyc == 3);
      if (start_mid && cyc == 3) Base = ~b;
      if (abort_after >= 0 && abort_cyc < 0 && got.size() == abort_after) begin
        Abort = 1'b1; StrReady = 1'b0; abort_cyc = cyc;
      end
      #1;
      pop = StrValid && StrReady;
      if (RamCE) begin
        ce_cnt++;
        addrs.push_back(RamAddr);
        if (issued - popped - int'(pop) >= 2) cred_viol++;
      end
      if (StrValid) valid_cnt++;
      if (prev_stall && (!StrValid || StrData !== prev_data)) hold_viol++;
      prev_stall = StrValid && !StrReady;
      prev_data  = StrData;
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1 && (StrValid || Busy)) post_abort_bad++;
      if (pop) begin got.push_back(StrData); popped++; end
      if (RamCE) issued++;
      busy_end = Busy;
      if (abort_after < 0 && done_cyc >= 0 && cyc >= done_cyc + 1) break;
      @(posedge Clock); #1;
    end
    Start = 1'b0; Abort = 1'b0; StrReady = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    run(v.base, v.len, v.ready_mode, -1, v.start_mid, 600);
    chk("byte_count", got.size(), v.exp_n);
    for (int i = 0; i < got.size() && i < v.exp_n; i++)
      chk("stream_byte", got[i], (v.exp_first + i) & 255);
    for (int i = 0; i < addrs.size(); i++)
      chk("ram_addr", addrs[i], (int'(v.base) + i) % 1024);
    chk("ramce_count", ce_cnt, v.exp_n);
    chk("done_pulses", done_cnt, 1);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    if (v.exp_valid >= 0) chk("valid_cycles", valid_cnt, v.exp_valid);
    chk("busy_after_done", busy_end, 0);
    chk("credit_rule", cred_viol, 0);
    chk("hold_while_stalled", hold_viol, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = i[DW-1:0];
`ifdef RAM_READER_SUM_EN
    mem[10'h200] = 8'hFF;
    mem[10'h201] = 8'h02;
    mem[10'h202] = 8'h10;
`endif
    vecs[0] = '{base: 10'h010, len: 4,  ready_mode: 0, start_mid: 0, exp_n: 4,  exp_first: 'h10, exp_done: 6,  exp_valid: 4};
    vecs[1] = '{base: 10'h3FE, len: 4,  ready_mode: 0, start_mid: 0, exp_n: 4,  exp_first: 'hFE, exp_done: 6,  exp_valid: 4};
    vecs[2] = '{base: 10'h100, len: 64, ready_mode: 1, start_mid: 0, exp_n: 64, exp_first: 'h00, exp_done: -1, exp_valid: -1};
    vecs[3] = '{base: 10'h000, len: 0,  ready_mode: 0, start_mid: 0, exp_n: 0,  exp_first: 'h00, exp_done: 0,  exp_valid: 0};
    vecs[4] = '{base: 10'h3FF, len: 1,  ready_mode: 0, start_mid: 0, exp_n: 1,  exp_first: 'hFF, exp_done: 3,  exp_valid: 1};
    vecs[5] = '{base: 10'h080, len: 16, ready_mode: 0, start_mid: 1, exp_n: 16, exp_first: 'h80, exp_done: 18, exp_valid: 16};

    // Outputs while held in reset
    #2;
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_ramce", RamCE, 0);
    chk("reset_ramwe", RamWE, 0);
    chk("reset_ramaddr", RamAddr, 0);
    chk("reset_strvalid", StrValid, 0);
    chk("reset_strdata", StrData, 0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Abort after three bytes of ten; the next transfer must run cleanly
    run(10'h020, 10, 0, 3, 1'b0, 12);
    chk("abort_byte_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("abort_byte", got[i], 'h20 + i);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_flushes_next_cycle", post_abort_bad, 0);
    chk("abort_busy_end", busy_end, 0);
    apply_vec(vecs[0]);

    // Reset asserted mid-transfer clears all outputs without waiting for a clock
    @(posedge Clock); #1;
    Base = 10'h040; Length = 11'd10; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0; StrReady = 1'b1;
    repeat (4) @(posedge Clock);
    #1;
    chk("pre_reset_busy", Busy, 1);
    chk("pre_reset_strvalid", StrValid, 1);
    #1 Reset = 1'b0;
    #1;
    chk("midreset_busy", Busy, 0);
    chk("midreset_done", Done, 0);
    chk("midreset_ramce", RamCE, 0);
    chk("midreset_ramaddr", RamAddr, 0);
    chk("midreset_strvalid", StrValid, 0);
    chk("midreset_strdata", StrData, 0);
    StrReady = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    apply_vec(vecs[1]);

`ifdef RAM_READER_SUM_EN
    run(10'h200, 3, 0, -1, 1'b0, 50);
    chk("sum_after_done", Sum, 'h11);
    @(posedge Clock); #1;
    Base = 10'h010; Length = 11'd2; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("sum_cleared_on_start", Sum, 0);
    StrReady = 1'b1;
    repeat (8) @(posedge Clock);
    #1;
    chk("sum_second_transfer", Sum, 'h10 + 'h11);
    StrReady = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
